vend_dispense_sched: RTL and testbench

//  Sequences the single shared dispense motor bus for the 4-slot vending machine and owns the per-slot stock counters.

---
 rtl/vend_dispense_sched_if.sv | 29 ++
 rtl/vend_dispense_sched.sv | 187 ++++++++++++++++++
 tb/tb_vend_dispense_sched.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/vend_dispense_sched_if.sv
// rtl/vend_dispense_sched_if.sv - vend/restock request and motor/stock status bundle
interface vend_dispense_sched_if #(
    parameter int STOCK_W = 6
);
    logic                   req_valid;
    logic [3:0]             req_mask;
    logic                   req_ready;
    logic                   rst_valid;
    logic [1:0]             rst_slot;
    logic [STOCK_W-1:0]     rst_qty;
    logic                   rst_ready;
    logic [3:0]             motor;
    logic                   busy;
    logic                   done;
    logic                   done_ok;
    logic [3:0]             done_mask;
    logic [4*STOCK_W-1:0]   stock;
    logic [3:0]             empty;

    modport master (
        output req_valid, req_mask, rst_valid, rst_slot, rst_qty,
        input  req_ready, rst_ready, motor, busy, done, done_ok, done_mask, stock, empty
    );

    modport slave (
        input  req_valid, req_mask, rst_valid, rst_slot, rst_qty,
        output req_ready, rst_ready, motor, busy, done, done_ok, done_mask, stock, empty
    );
endinterface

// File: rtl/vend_dispense_sched.sv
// rtl/vend_dispense_sched.sv - shared dispense motor sequencer and stock owner (option: PARTIAL_VEND_EN)
module vend_dispense_sched #(
    parameter int STOCK_W    = 6,
    parameter int STOCK_INIT = 3,
    parameter int PULSE_CYC  = 8,
    parameter int GAP_CYC    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    vend_dispense_sched_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_PULSE, S_GAP, S_DONE} state_t;

    localparam logic [STOCK_W-1:0] STOCK_MAX = '1;
    localparam logic [STOCK_W-1:0] INIT_V    = STOCK_W'(STOCK_INIT);
    localparam logic [7:0]         PULSE_LD  = 8'(PULSE_CYC - 1);
    localparam logic [7:0]         GAP_LD    = 8'(GAP_CYC - 1);

    state_t             state_q, state_d;
    logic [3:0]         mask_q, mask_d;
    logic [1:0]         cur_q, cur_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [3:0]         motor_q, motor_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               done_ok_q, done_ok_d;
    logic [3:0]         done_mask_q, done_mask_d;
    logic               ok_q, ok_d;
    logic [STOCK_W-1:0] stock_q [4];
    logic [STOCK_W-1:0] stock_d [4];
    logic [3:0]         empty_w;
    logic [3:0]         sold;
    logic [3:0]         avail;
    logic [STOCK_W:0]   sum;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        if (m[0]) return 2'd0;
        if (m[1]) return 2'd1;
        if (m[2]) return 2'd2;
        return 2'd3;
    endfunction

    // Decode per-slot empty flags and pack the stock bus
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            empty_w[i] = (stock_q[i] == '0);
            bus.stock[i*STOCK_W +: STOCK_W] = stock_q[i];
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rst_ready = (state_q == S_IDLE) && !bus.req_valid;
    assign bus.empty     = empty_w;
    assign bus.motor     = motor_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.done_ok   = done_ok_q;
    assign bus.done_mask = done_mask_q;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        motor_d     = motor_q;
        done_d      = 1'b0;
        done_ok_d   = done_ok_q;
        done_mask_d = done_mask_q;
        ok_d        = ok_q;
        stock_d     = stock_q;
        sum         = '0;
        sold        = mask_q & empty_w;
        avail       = mask_q & ~empty_w;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    mask_d      = bus.req_mask;
                    done_mask_d = '0;
                    state_d     = S_CHECK;
                end else if (bus.rst_valid) begin
                    sum = {1'b0, stock_q[bus.rst_slot]} + {1'b0, bus.rst_qty};
                    stock_d[bus.rst_slot] = sum[STOCK_W] ? STOCK_MAX : sum[STOCK_W-1:0];
                end
            end
            S_CHECK: begin
`ifdef PARTIAL_VEND_EN
                ok_d   = (sold == 4'b0);
                mask_d = avail;
                if (avail == 4'b0) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    done_ok_d = (sold == 4'b0);
                end else begin
                    cur_d   = lowest(avail);
                    motor_d = 4'b0001 << lowest(avail);
                    cnt_d   = PULSE_LD;
                    state_d = S_PULSE;
                end
`else
                ok_d = 1'b1;
                if (sold != 4'b0) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    done_ok_d   = 1'b0;
                    done_mask_d = '0;
                end else if (mask_q == 4'b0) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    done_ok_d = 1'b1;
                end else begin
                    cur_d   = lowest(mask_q);
                    motor_d = 4'b0001 << lowest(mask_q);
                    cnt_d   = PULSE_LD;
                    state_d = S_PULSE;
                end
`endif
            end
            S_PULSE: begin
                if (cnt_q == 8'd0) begin
                    if (stock_q[cur_q] != '0) begin
                        stock_d[cur_q] = stock_q[cur_q] - 1'b1;
                    end
                    done_mask_d[cur_q] = 1'b1;
                    mask_d[cur_q]      = 1'b0;
                    motor_d            = 4'b0;
                    cnt_d              = GAP_LD;
                    state_d            = S_GAP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 8'd0) begin
                    if (mask_q != 4'b0) begin
                        cur_d   = lowest(mask_q);
                        motor_d = 4'b0001 << lowest(mask_q);
                        cnt_d   = PULSE_LD;
                        state_d = S_PULSE;
                    end else begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        done_ok_d = ok_q;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                done_ok_d   = 1'b0;
                done_mask_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any drink in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            cur_q       <= '0;
            cnt_q       <= '0;
            motor_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_ok_q   <= 1'b0;
            done_mask_q <= '0;
            ok_q        <= 1'b0;
            for (int i = 0; i < 4; i++) stock_q[i] <= INIT_V;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            motor_q     <= motor_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_ok_q   <= done_ok_d;
            done_mask_q <= done_mask_d;
            ok_q        <= ok_d;
            stock_q     <= stock_d;
        end
    end
endmodule

// File: tb/tb_vend_dispense_sched.sv
// tb/tb_vend_dispense_sched.sv - scoreboard bench for vend_dispense_sched
module tb_vend_dispense_sched;
    localparam int SW   = 6;
    localparam int INIT = 3;
    localparam int P    = 8;
    localparam int G    = 4;
    localparam int SMAX = (1 << SW) - 1;

    typedef struct {
        int         acc;
        logic       ok;
        logic [3:0] served;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vend_dispense_sched_if #(.STOCK_W(SW)) bus ();

    vend_dispense_sched #(
        .STOCK_W(SW), .STOCK_INIT(INIT), .PULSE_CYC(P), .GAP_CYC(G)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    exp_t sbq[$];
    int   mstock[4];
    int   cyc = 0;
    bit   hold = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    int         mon_t;
    bit         mon_act;
    logic [3:0] mon_em;
    int         mon_j;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: expected motor per cycle and done fields at the predicted cycle
    always @(negedge clk) begin
        if (!hold) begin
            mon_em  = 4'b0;
            mon_act = 1'b0;
            mon_t   = 0;
            if (sbq.size() > 0 && cyc >= sbq[0].acc) begin
                mon_act = 1'b1;
                mon_t   = cyc - sbq[0].acc;
                mon_j   = 0;
                for (int i = 0; i < 4; i++) begin
                    if (sbq[0].served[i]) begin
                        if (mon_t >= 1 + mon_j*(P+G) && mon_t < 1 + mon_j*(P+G) + P)
                            mon_em = 4'(1 << i);
                        mon_j++;
                    end
                end
            end
            chk("motor", int'(bus.motor), int'(mon_em));
            if (mon_act && mon_t == sbq[0].lat) begin
                chk("done", int'(bus.done), 1);
                chk("done_ok", int'(bus.done_ok), int'(sbq[0].ok));
                chk("done_mask", int'(bus.done_mask), int'(sbq[0].served));
                void'(sbq.pop_front());
            end else begin
                chk("done_quiet", int'(bus.done), 0);
            end
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!bus.busy && sbq.size() == 0) return;
        end
        chk("idle_timeout", 0, 1);
        sbq.delete();
    endtask

    task automatic check_stock();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stock%0d", i), int'(bus.stock[i*SW +: SW]), mstock[i]);
            chk($sformatf("empty%0d", i), int'(bus.empty[i]), int'(mstock[i] == 0));
        end
    endtask

    task automatic wait_done();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            if (sbq.size() == 0) begin
                check_stock();
                return;
            end
        end
        chk("done_timeout", 0, 1);
        sbq.delete();
    endtask

    task automatic issue_vend(input logic [3:0] m, input bit collide, input bit no_wait);
        exp_t       e;
        logic [3:0] sold;
        wait_idle();
        sold = 4'b0;
        for (int i = 0; i < 4; i++) if (m[i] && mstock[i] == 0) sold[i] = 1'b1;
`ifdef PARTIAL_VEND_EN
        e.served = m & ~sold;
`else
        e.served = (sold != 4'b0) ? 4'b0 : m;
`endif
        e.ok  = (sold == 4'b0);
        e.lat = 1 + $countones(e.served) * (P + G);
        e.acc = cyc + 1;
        for (int i = 0; i < 4; i++) if (e.served[i]) mstock[i]--;
        bus.req_mask  = m;
        bus.req_valid = 1'b1;
        if (collide) begin
            bus.rst_valid = 1'b1;
            bus.rst_slot  = 2'd1;
            bus.rst_qty   = 6'd5;
        end
        sbq.push_back(e);
        #1;
        chk("req_ready", int'(bus.req_ready), 1);
        if (collide) chk("rst_ready_collide", int'(bus.rst_ready), 0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.rst_valid = 1'b0;
        if (!no_wait) wait_done();
    endtask

    task automatic issue_restock(input int s, input int q);
        wait_idle();
        bus.rst_slot  = 2'(s);
        bus.rst_qty   = SW'(q);
        bus.rst_valid = 1'b1;
        #1;
        chk("rst_ready", int'(bus.rst_ready), 1);
        @(posedge clk);
        #1;
        bus.rst_valid = 1'b0;
        mstock[s] = (mstock[s] + q > SMAX) ? SMAX : mstock[s] + q;
        @(negedge clk);
        #1;
        check_stock();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_mask  = 4'b0;
        bus.rst_valid = 1'b0;
        bus.rst_slot  = 2'd0;
        bus.rst_qty   = '0;
        for (int i = 0; i < 4; i++) mstock[i] = INIT;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #2;
        hold = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_ready_idle", int'(bus.req_ready), 1);
        check_stock();

        issue_vend(4'b0001, 1'b0, 1'b0);
        issue_vend(4'b1010, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) issue_vend(4'b0100, 1'b0, 1'b0);
        issue_vend(4'b0100, 1'b0, 1'b0);
`ifdef PARTIAL_VEND_EN
        issue_vend(4'b0101, 1'b0, 1'b0);
`endif
        issue_vend(4'b0001, 1'b1, 1'b0);
        issue_restock(1, 63);

        issue_vend(4'b0010, 1'b0, 1'b1);
        while (cyc < sbq[0].acc + 4) @(negedge clk);
        #2;
        hold  = 1'b1;
        reset = 1'b0;
        #1;
        chk("reset_motor", int'(bus.motor), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_busy", int'(bus.busy), 0);
        sbq.delete();
        for (int i = 0; i < 4; i++) mstock[i] = INIT;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk);
        #2;
        hold = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("post_reset_busy", int'(bus.busy), 0);
        check_stock();

        issue_vend(4'b0000, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0)
                issue_restock(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
            else
                issue_vend(4'($urandom_range(0, 15)), 1'b0, 1'b0);
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
